// File: rtl/bridge_pkg.sv
// Shared definitions for the UART-to-bus debug/loader bridge: FSM state
// encoding, default protocol bytes and command field lengths.
package bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_MEM  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Default protocol bytes
  localparam logic [7:0] CMD_READ_DEF  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_WRITE_DEF = 8'h57;  // 'W'
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;

  // Command field lengths in bytes (little-endian on the wire)
  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 4;

  // Number of response bytes returned for a read
  localparam logic [2:0] READ_RESP_BYTES = 3'd4;

endpackage

// File: rtl/uart_bus_bridge.sv
// UART byte-stream command parser acting as a word-wide bus initiator.
// Commands: 'R' A0..A3 -> read word, reply D0..D3; 'W' A0..A3 D0..D3 ->
// write word, reply ACK; any other leading byte -> reply NAK.
//
// Handshakes: a bus beat completes on the cycle mem_valid && mem_ready; a
// response byte is consumed on the cycle tx_valid && tx_ready. mem_valid and
// tx_valid stay high with stable payload until their handshake, and drop on
// the following cycle unless another beat/byte is pending. rx_valid is a
// one-cycle strobe with no back-pressure; bytes arriving while a transaction
// or response is in flight are dropped and flagged in the sticky overrun bit.
module uart_bus_bridge
  import bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] CMD_READ       = CMD_READ_DEF,
  parameter logic [7:0] CMD_WRITE      = CMD_WRITE_DEF,
  parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE       = NAK_BYTE_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        overrun
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = '1;
  localparam logic [1:0]    ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0]    DATA_LAST = 2'(DATA_BYTES - 1);

  state_t        state, state_next;
  logic          is_write, is_write_next;
  logic [1:0]    byte_idx, byte_idx_next;
  logic [31:0]   addr, addr_next;
  logic [31:0]   wdata, wdata_next;
  logic [31:0]   resp, resp_next;
  logic [2:0]    resp_cnt, resp_cnt_next;
  logic [TW-1:0] to_cnt;
  logic          timed_out;

  assign timed_out = (to_cnt == TO_LAST);

  // Next-state and next-datapath decode; every register holds by default.
  always_comb begin
    state_next    = state;
    is_write_next = is_write;
    byte_idx_next = byte_idx;
    addr_next     = addr;
    wdata_next    = wdata;
    resp_next     = resp;
    resp_cnt_next = resp_cnt;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
            is_write_next = (rx_data == CMD_WRITE);
            byte_idx_next = 2'd0;
            state_next    = S_ADDR;
          end else begin
            resp_next     = {24'h0, NAK_BYTE};
            resp_cnt_next = 3'd1;
            state_next    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        // An arriving byte takes priority over a coincident timeout.
        if (rx_valid) begin
          addr_next[{byte_idx, 3'b000} +: 8] = rx_data;
          byte_idx_next = byte_idx + 2'd1;
          if (byte_idx == ADDR_LAST) begin
            byte_idx_next = 2'd0;
            state_next    = is_write ? S_DATA : S_MEM;
          end
        end else if (timed_out) begin
          state_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          wdata_next[{byte_idx, 3'b000} +: 8] = rx_data;
          byte_idx_next = byte_idx + 2'd1;
          if (byte_idx == DATA_LAST) begin
            byte_idx_next = 2'd0;
            state_next    = S_MEM;
          end
        end else if (timed_out) begin
          state_next = S_IDLE;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_write) begin
            resp_next     = {24'h0, ACK_BYTE};
            resp_cnt_next = 3'd1;
          end else begin
            resp_next     = mem_rdata;
            resp_cnt_next = READ_RESP_BYTES;
          end
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          resp_next     = {8'h00, resp[31:8]};
          resp_cnt_next = resp_cnt - 3'd1;
          if (resp_cnt == 3'd1) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      is_write <= 1'b0;
      byte_idx <= 2'd0;
      addr     <= 32'h0;
      wdata    <= 32'h0;
      resp     <= 32'h0;
      resp_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      is_write <= is_write_next;
      byte_idx <= byte_idx_next;
      addr     <= addr_next;
      wdata    <= wdata_next;
      resp     <= resp_next;
      resp_cnt <= resp_cnt_next;
    end
  end

  // Inter-byte gap counter: runs only while a command is being collected,
  // clears on every received byte and whenever the parser is elsewhere.
  always_ff @(posedge clk) begin
    if (!resetn || rx_valid || !(state == S_ADDR || state == S_DATA)) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Sticky flag for bytes dropped while a transaction/response is in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun <= 1'b0;
    end else if (rx_valid && (state == S_MEM || state == S_RESP)) begin
      overrun <= 1'b1;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
    end else begin
      mem_valid <= (state_next == S_MEM);
      mem_addr  <= {addr_next[31:2], 2'b00};
      mem_wdata <= wdata_next;
      mem_wstrb <= (state_next == S_MEM && is_write_next) ? 4'b1111 : 4'b0000;
      tx_valid  <= (state_next == S_RESP);
      tx_data   <= resp_next[7:0];
      busy      <= (state_next != S_IDLE);
    end
  end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Debug/loader bridge that parses a byte-stream command protocol and issues word-wide transactions as a bus initiator on the SoC valid/ready memory interface. It is the initiator counterpart to the SoC's memory responders (BRAM, SDRAM, IO). It sits between a UART receiver/transmitter byte pair and the memory arbiter, so a host can peek and poke memory without the CPU.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000, inter-byte gap after which a partial command is discarded (must be ≥ 2)
- CMD_READ, 8'h52, read opcode ('R')
- CMD_WRITE, 8'h57, write opcode ('W')
- ACK_BYTE, 8'h06, write-complete response
- NAK_BYTE, 8'h15, unknown-opcode response

Ports:
- clk  in  1  clock
- resetn  in  1  reset: synchronous, active-low, on clk
- rx_valid  in  1  single-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_valid  out  1  response byte available
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
- tx_data  out  8  response byte, stable while tx_valid
- mem_valid  out  1  bus request
- mem_ready  in  1  responder completion, one cycle
- mem_addr  out  32  byte address, bits [1:0] forced 0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b1111 write, 4'b0000 read
- mem_rdata  in  32  read data, valid when mem_ready
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky: byte arrived while not accepting input

## Operation
- Commands (multi-byte fields little-endian): read = CMD_READ, A0..A3; write = CMD_WRITE, A0..A3, D0..D3.
- FSM states: IDLE, ADDR, DATA, MEM, RESP.
- IDLE: on rx_valid: CMD_READ/CMD_WRITE → latch op, byte_idx=0, → ADDR; other byte → load NAK_BYTE, resp_cnt=1, → RESP.
- ADDR: each rx_valid shifts byte into addr[8*byte_idx+:8], byte_idx++; after 4th byte: read → MEM, write → DATA (byte_idx=0).
- DATA: same, into wdata; after 4th byte → MEM.
- MEM: mem_valid=1 with stable addr/wdata/wstrb until mem_ready sampled high; mem_valid low on the next cycle. Read: capture mem_rdata into resp shift reg, resp_cnt=4. Write: resp=ACK_BYTE, resp_cnt=1. → RESP.
- RESP: tx_valid=1, tx_data=resp[7:0]; on tx_ready: shift resp right 8, resp_cnt--; at 0 → IDLE.
- Timeout: counter cleared on every accepted byte and on IDLE entry; in ADDR/DATA reaching TIMEOUT_CYCLES-1 → IDLE, no response. No timeout in MEM/RESP.
- rx_valid in MEM or RESP: byte dropped, overrun←1.
- Counters: byte_idx 2-bit, resp_cnt 3-bit, timeout $clog2(TIMEOUT_CYCLES)-bit saturating.

## Timing
- Reset values: state IDLE; tx_valid, mem_valid, busy, overrun = 0; tx_data, mem_addr, mem_wdata, mem_wstrb = 0. Reset mid-transaction abandons it immediately, mem_valid low the next cycle.
- All outputs registered.
- mem_valid rises the cycle after the last command byte's rx_valid.
- mem_ready sampled in cycle N → mem_valid low in N+1, tx_valid high in N+1.
- Compatible with responders that gate valid with !ready: mem_valid is never held high for more than one cycle after mem_ready.
- tx byte k+1 presented the cycle after byte k's handshake; busy falls the cycle after the final tx handshake.
- rx_valid and a timeout in the same cycle: the byte wins and the counter clears.

## Structure
- Shared package `bridge_pkg`: state enum, CMD_/ACK_/NAK_ defaults, command length constants (ADDR_BYTES=4, DATA_BYTES=4).
- Single module; no sub-module. The timeout counter stays inline.

## Test plan
- Write: bytes 57 10 00 00 80 EF BE AD DE → one mem txn addr 0x80000010, wdata 0xDEADBEEF, wstrb 1111; tx 06.
- Read: 52 13 00 00 80, responder returns 0x12345678 after 3-cycle wait → mem_addr 0x80000010, wstrb 0000, mem_valid held 3 cycles then drops; tx 78 56 34 12 in order.
- Unknown 0x41 → no mem txn, tx 15, back to IDLE.
- Partial 52 00 then gap ≥ TIMEOUT_CYCLES (set 16) → no mem txn, no tx, busy low; following full read succeeds.
- tx_ready held low 10 cycles during read response → tx_data stable; extra rx byte during RESP → overrun=1, response unaffected.
- Reset asserted while mem_valid high → mem_valid=0, busy=0 after one cycle; next command processed normally.
